pwm_bank: RTL
=============

# pwm_bank

Parametrised multi-channel PWM generator that succeeds the fixed eight `pwm*_io` outputs of `synth_top`. It sits on the core's memory-mapped bus and decodes writes to a small register window. It holds per-channel duty cycles in double-buffered registers and drives `CHANNELS` PWM pins from one shared, prescaled period counter. It adds two things the fixed outputs lack: glitch-free duty updates at period boundaries, and an optional phase-staggered mode.

## Interface
- `CHANNELS`, 8: number of PWM outputs; power of two; 1..2^`WIDTH`.
- `WIDTH`, 8: duty and counter width in bits; 2..16.
- `ADDR_W`, 10: bus address width.
- `BASE_ADDR`, 10'h3F0: first address of the register window.
- `clk_io` in 1: the only clock. Everything is on the rising edge.
- `reset_io` in 1: asynchronous, active-low reset.
- `addr_in` in `ADDR_W`: bus address.
- `data_in` in 16: bus write data.
- `wr_en_in` in 1: write strobe, sampled on the rising edge.
- `rd_data_out` out 16: registered readback of the register at `addr_in`.
- `pwm_out` out `CHANNELS`: PWM outputs. Bit i is channel i.
- `period_tick_out` out 1: one-cycle pulse per counter wrap.

## Operation
- Register map, at offset from `BASE_ADDR`:
  - Offsets 0..`CHANNELS`-1 are `DUTY[i]`, taken from `data_in[WIDTH-1:0]`.
  - Offset `CHANNELS` is `CTRL`:
    - bit0 `EN`.
    - bit1 `STAGGER`.
    - bits[15:8] `PRE`.
    - All other bits are reserved; they read back as 0 and writes to them are ignored.
- Writes outside the window are ignored.
- Each channel has a `staging` register (written by the bus) and an `active` register (used by the compare).
- Prescaler counter `pc`:
  - `tick` = `EN && pc >= PRE`.
  - On `tick`: `pc` goes to 0 and `cnt` goes to `cnt+1`, modulo 2^`WIDTH`.
  - Otherwise `pc` goes to `pc+1`.
  - The `>=` compare means lowering `PRE` mid-count never stalls the counter.
- `wrap` = `tick && cnt == 2^WIDTH-1`.
  - On `wrap`, every `active[i]` loads `staging[i]`.
  - If a same-edge write hits `DUTY[i]`, `active[i]` loads the write data instead. A simultaneous write is never lost or delayed by a period.
- Compare value for channel i:
  - `cnt_i` = `cnt` when `STAGGER`=0.
  - `cnt_i` = (`cnt` + i·2^`WIDTH`/`CHANNELS`) mod 2^`WIDTH` when `STAGGER`=1.
- `pwm_out[i]` is registered: `EN && cnt_i < active[i]`.
  - Duty 0 gives constant low.
  - Duty 2^`WIDTH`-1 gives high for all but one count per period.
- `EN`=0:
  - `pc` and `cnt` are held at 0.
  - `pwm_out` = 0 and `period_tick_out` = 0.
  - `active[i]` loads `staging[i]` every cycle, so enabling starts with the latest duties.
- Clearing `EN` mid-period stops output on the next edge. No period is completed.
- `STAGGER` and `PRE` changes take effect on the next edge. Neither waits for a wrap.

## Timing
- Reset values:
  - `staging`, `active`, `CTRL`, `pc`, `cnt` = 0.
  - `pwm_out` = 0, `period_tick_out` = 0, `rd_data_out` = 0.
- Reset assertion mid-period forces all of the above immediately, asynchronously.
- Write latency: the register is updated at the edge that samples `wr_en_in`.
- Readback: `rd_data_out` equals the register addressed by `addr_in` one cycle after `addr_in` is presented.
  - `DUTY[i]` reads back the staging value, zero-extended.
  - Unmapped addresses read 0.
  - Reads have no side effects.
- `pwm_out` lags `cnt` by one cycle.
- `period_tick_out` is high for exactly one cycle: the cycle after the `wrap` edge. That is also the first output cycle of the new period.
- Period length = 2^`WIDTH`·(`PRE`+1) clocks.

## Structure
- Shared package `synth_pkg`:
  - Register offsets: `DUTY` base = 0, `CTRL` = `CHANNELS`.
  - `CTRL` bit positions: `EN`, `STAGGER`, `PRE` field.
  - Readback-zero constant.
- Sub-module `pwm_channel`, instantiated `CHANNELS` times:
  - Contains the staging and active registers, the write-through mux, the stagger offset add and the registered compare.
  - Parameters are `WIDTH` and `INDEX`.
- The top level holds the decode, `CTRL`, the prescaler, the counter and the readback mux.

## Test plan
All scenarios use `CHANNELS`=4, `WIDTH`=4, `BASE_ADDR`=0x3F0.

- **Basic duty:** write `DUTY0`=4, then `CTRL`=0x0001 (`PRE`=0, `EN`=1) -> `pwm_out[0]` high 4 of every 16 clocks, `period_tick_out` pulses every 16 clocks, `pwm_out[3:1]` = 0.
- **Prescaler and extremes:** `PRE`=2, `DUTY1`=15, `DUTY2`=0 -> period 48 clocks, `pwm_out[1]` low for exactly 3 clocks per period, `pwm_out[2]` never high.
- **Double buffering:** running with `DUTY0`=4, write `DUTY0`=10 when `cnt`=7 -> current period finishes with 4 high clocks, next period has 10. Repeat with the write on the `wrap` edge -> 10 applies in the very next period.
- **Stagger:** all `DUTY`=4, `CTRL`=0x0003 -> channel rising edges offset by 4 clocks, with channel i rising at `cnt`=(16-4i) mod 16. Clearing `STAGGER` realigns all channels on the next edge.
- **Readback and decode:** write 0xABCD to `DUTY2` -> `rd_data_out`=0x000D one cycle after `addr_in`=0x3F2. Write to 0x3F5 -> no state change and reads 0. `CTRL`=0xFFFF reads back 0xFF03.
- **Reset and disable:** drive `reset_io` low mid-period -> all outputs are 0 without waiting for a clock edge and registers are cleared. Separately, clear `EN` mid-period -> `pwm_out`=0 next cycle. Re-enabling restarts at `cnt`=0 with the latest duties.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - register map constants shared by the PWM bank
//
// Purpose: register offsets, CTRL field positions and the readback-zero
// constant, so decode and readback agree on a single definition.
// Ports: none (package).
package synth_pkg;

  // DUTY[i] sits at DUTY_BASE + i; CTRL follows the last channel.
  localparam int DUTY_BASE = 0;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_STAGGER_BIT = 1;
  localparam int CTRL_PRE_LSB     = 8;
  localparam int CTRL_PRE_W       = 8;

  localparam logic [15:0] RD_ZERO = 16'h0000;

  function automatic int ctrl_offset(input int channels);
    return DUTY_BASE + channels;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: double-buffered duty and registered compare
//
// Purpose: holds the bus-written staging duty and the active duty used by the
// compare, applies the stagger phase offset and registers the PWM output.
// Ports:
//   clk_io, reset_io  clock, asynchronous active-low reset
//   en                output enable (low forces pwm to 0)
//   load              active duty reloads this cycle (wrap or disabled)
//   wr_en, wr_data    bus write to this channel's DUTY register
//   cnt               shared period counter
//   stagger           apply the per-channel phase offset
//   phase_step        counter offset between adjacent channels
//   staging           staging duty, for readback
//   pwm               registered PWM output
module pwm_channel #(
  parameter int WIDTH = 8,
  parameter int INDEX = 0
) (
  input  logic             clk_io,
  input  logic             reset_io,
  input  logic             en,
  input  logic             load,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] cnt,
  input  logic             stagger,
  input  logic [WIDTH-1:0] phase_step,
  output logic [WIDTH-1:0] staging,
  output logic             pwm
);

  localparam logic [WIDTH-1:0] IDX = WIDTH'(INDEX);

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] cnt_i;

  // Offset add wraps naturally at WIDTH bits, giving the modulo.
  always_comb begin
    cnt_i = cnt;
    if (stagger) cnt_i = cnt + IDX * phase_step;
  end

  always_ff @(posedge clk_io or negedge reset_io) begin
    if (!reset_io) begin
      staging <= '0;
      active  <= '0;
      pwm     <= 1'b0;
    end else begin
      if (wr_en) staging <= wr_data;
      // Write-through: a DUTY write landing on a load edge goes straight to
      // active so it is not deferred by a whole period.
      if (load) active <= wr_en ? wr_data : staging;
      pwm <= en && (cnt_i < active);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM generator with shared prescaled counter
//
// Purpose: decodes a bus register window (DUTY[0..CHANNELS-1], CTRL), runs
// the prescaler and period counter, and drives CHANNELS PWM outputs with
// period-boundary duty updates and optional phase staggering.
// Ports:
//   clk_io           clock
//   reset_io         asynchronous active-low reset
//   addr_in          bus address
//   data_in          bus write data
//   wr_en_in         write strobe
//   rd_data_out      registered readback of the register at addr_in
//   pwm_out          PWM outputs, bit i is channel i
//   period_tick_out  one-cycle pulse after each counter wrap
module pwm_bank
  import synth_pkg::*;
#(
  parameter int                CHANNELS  = 8,
  parameter int                WIDTH     = 8,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h3F0
) (
  input  logic                clk_io,
  input  logic                reset_io,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [15:0]         data_in,
  input  logic                wr_en_in,
  output logic [15:0]         rd_data_out,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick_out
);

  localparam int               CTRL_OFF   = ctrl_offset(CHANNELS);
  localparam logic [WIDTH-1:0] PHASE_STEP = WIDTH'((1 << WIDTH) / CHANNELS);

  logic                  en;
  logic                  stagger;
  logic [CTRL_PRE_W-1:0] pre;
  logic [CTRL_PRE_W-1:0] pc;
  logic [WIDTH-1:0]      cnt;

  logic        in_win;
  logic [31:0] off;
  logic        hit_ctrl;
  logic        ctrl_wr;
  logic        next_en;
  logic        out_en;
  logic        tick;
  logic        wrap;
  logic        load_all;
  logic [15:0] rd_next;
  logic [15:0] ctrl_rd;

  logic [WIDTH-1:0] staging [CHANNELS];

  always_comb begin
    in_win   = (addr_in >= BASE_ADDR);
    off      = 32'(addr_in - BASE_ADDR);
    hit_ctrl = in_win && (off == 32'(CTRL_OFF));
    ctrl_wr  = wr_en_in && hit_ctrl;
    next_en  = ctrl_wr ? data_in[CTRL_EN_BIT] : en;
    // Enabling waits for the CTRL register so the first compare sees cnt=0;
    // disabling takes effect on the writing edge so no extra cycle leaks out.
    out_en   = en && next_en;
    tick     = en && (pc >= pre);
    wrap     = tick && (cnt == {WIDTH{1'b1}});
    // While disabled, active tracks staging so enabling uses the latest duties.
    load_all = !en || wrap;
  end

  always_comb begin
    ctrl_rd                                     = RD_ZERO;
    ctrl_rd[CTRL_EN_BIT]                        = en;
    ctrl_rd[CTRL_STAGGER_BIT]                   = stagger;
    ctrl_rd[CTRL_PRE_LSB +: CTRL_PRE_W]         = pre;
    rd_next = RD_ZERO;
    if (hit_ctrl) rd_next = ctrl_rd;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_win && (off == 32'(DUTY_BASE + i))) rd_next = 16'(staging[i]);
    end
  end

  always_ff @(posedge clk_io or negedge reset_io) begin
    if (!reset_io) begin
      en              <= 1'b0;
      stagger         <= 1'b0;
      pre             <= '0;
      pc              <= '0;
      cnt             <= '0;
      period_tick_out <= 1'b0;
      rd_data_out     <= RD_ZERO;
    end else begin
      if (ctrl_wr) begin
        en      <= data_in[CTRL_EN_BIT];
        stagger <= data_in[CTRL_STAGGER_BIT];
        pre     <= data_in[CTRL_PRE_LSB +: CTRL_PRE_W];
      end
      if (!en) begin
        pc  <= '0;
        cnt <= '0;
      end else if (tick) begin
        pc  <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        pc  <= pc + 1'b1;
      end
      period_tick_out <= wrap && next_en;
      rd_data_out     <= rd_next;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic duty_wr;
    assign duty_wr = wr_en_in && in_win && (off == 32'(DUTY_BASE + i));

    pwm_channel #(
      .WIDTH(WIDTH),
      .INDEX(i)
    ) u_ch (
      .clk_io    (clk_io),
      .reset_io  (reset_io),
      .en        (out_en),
      .load      (load_all),
      .wr_en     (duty_wr),
      .wr_data   (data_in[WIDTH-1:0]),
      .cnt       (cnt),
      .stagger   (stagger),
      .phase_step(PHASE_STEP),
      .staging   (staging[i]),
      .pwm       (pwm_out[i])
    );
  end

endmodule
